// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake between the fetch stage (master) and the memory (slave).
// One read is outstanding at a time; the slave answers with a single-cycle imem_resp strobe.
interface fetch_stage_if;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_resp;

    modport master (
        output imem_address,
        output imem_read,
        input  imem_rdata,
        input  imem_resp
    );

    modport slave (
        input  imem_address,
        input  imem_read,
        output imem_rdata,
        output imem_resp
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline: owns the PC, runs the imem handshake and predicts next_pc
// from a 2-bit-counter BHT (conditional branches) plus direct JAL targets.
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0060,
    parameter int          BHT_IDX_BITS = 6
) (
    input  logic               clk,
    input  logic               rst,
    fetch_stage_if.master      imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic               bht_update,
    input  logic [31:0]        bht_update_pc,
    input  logic               bht_update_taken,
    output logic [31:0]        pc_out,
    output logic [31:0]        pc_plus4_out,
    output logic [31:0]        next_pc_out,
    output logic [31:0]        instr_out,
    output logic               predicted_direction_out,
    output logic               instr_valid
);

    localparam int         BHT_SIZE  = 1 << BHT_IDX_BITS;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  pending_pc, pending_next;
    logic [31:0]  hold_instr, hold_next;
    logic         deliver;

    logic [1:0]   bht [BHT_SIZE];

    logic [31:0]             fetch_word;
    logic [6:0]              opcode;
    logic [31:0]             b_imm;
    logic [31:0]             j_imm;
    logic [BHT_IDX_BITS-1:0] lookup_idx;
    logic [BHT_IDX_BITS-1:0] update_idx;
    logic [1:0]              lookup_counter;
    logic [31:0]             predicted_pc;
    logic                    predicted_taken;
    logic                    unused_update_bits;

    // The delivered word comes straight from memory in FETCH (zero added latency) or from the buffer in HOLD.
    assign fetch_word     = (state == HOLD) ? hold_instr : imem.imem_rdata;
    assign opcode         = fetch_word[6:0];
    assign b_imm          = {{20{fetch_word[31]}}, fetch_word[7], fetch_word[30:25],
                             fetch_word[11:8], 1'b0};
    assign j_imm          = {{12{fetch_word[31]}}, fetch_word[19:12], fetch_word[20],
                             fetch_word[30:21], 1'b0};
    assign lookup_idx     = pc[BHT_IDX_BITS+1:2];
    assign update_idx     = bht_update_pc[BHT_IDX_BITS+1:2];
    assign lookup_counter = bht[lookup_idx];
    assign unused_update_bits = ^{bht_update_pc[31:BHT_IDX_BITS+2], bht_update_pc[1:0]};

    always_comb begin
        predicted_pc    = pc + 32'd4;
        predicted_taken = 1'b0;
        if (opcode == OP_BRANCH && lookup_counter[1]) begin
            predicted_pc    = pc + b_imm;
            predicted_taken = 1'b1;
        end else if (opcode == OP_JAL) begin
            predicted_pc    = pc + j_imm;
            predicted_taken = 1'b1;
        end
    end

    // Redirect outranks everything; a redirect during an outstanding read must wait for that read to drain.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        pending_next = pending_pc;
        hold_next    = hold_instr;
        deliver      = 1'b0;
        case (state)
            FETCH: begin
                if (redirect) begin
                    if (imem.imem_resp) begin
                        pc_next = redirect_pc;
                    end else begin
                        pending_next = redirect_pc;
                        state_next   = DISCARD;
                    end
                end else if (imem.imem_resp) begin
                    if (stall) begin
                        hold_next  = imem.imem_rdata;
                        state_next = HOLD;
                    end else begin
                        deliver = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    hold_next  = '0;
                    pc_next    = redirect_pc;
                    state_next = FETCH;
                end else if (!stall) begin
                    deliver = 1'b1;
                end
            end
            DISCARD: begin
                if (imem.imem_resp) begin
                    pc_next    = redirect ? redirect_pc : pending_pc;
                    state_next = FETCH;
                end else if (redirect) begin
                    pending_next = redirect_pc;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
        if (deliver) begin
            pc_next    = predicted_pc;
            state_next = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            pending_pc <= '0;
            hold_instr <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            pending_pc <= pending_next;
            hold_instr <= hold_next;
        end
    end

    // Saturating counters; a lookup of the index being updated this cycle still sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_SIZE; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (bht_update) begin
            if (bht_update_taken) begin
                if (bht[update_idx] != 2'b11) begin
                    bht[update_idx] <= bht[update_idx] + 2'b01;
                end
            end else begin
                if (bht[update_idx] != 2'b00) begin
                    bht[update_idx] <= bht[update_idx] - 2'b01;
                end
            end
        end
    end

    // During the reset cycle every output is forced quiet, whatever state the registers hold.
    assign imem.imem_read          = !rst && (state != HOLD);
    assign imem.imem_address       = rst ? 32'd0 : pc;
    assign instr_valid             = !rst && deliver;
    assign pc_out                  = rst ? 32'd0 : pc;
    assign pc_plus4_out            = rst ? 32'd0 : (pc + 32'd4);
    assign next_pc_out             = rst ? 32'd0 : predicted_pc;
    assign instr_out               = rst ? 32'd0 : fetch_word;
    assign predicted_direction_out = !rst && predicted_taken;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays instruction memory, hazard unit and EX,
// with hand-computed expectations for every checked output.
module tb_fetch_stage;

    localparam logic [31:0] ADDI1 = 32'h0010_0093;
    localparam logic [31:0] ADDI2 = 32'h0020_0113;
    localparam logic [31:0] JAL   = 32'h1000_006F;
    localparam logic [31:0] BEQ   = 32'hFE00_0CE3;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        bht_update;
    logic [31:0] bht_update_pc;
    logic        bht_update_taken;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic [31:0] next_pc_out;
    logic [31:0] instr_out;
    logic        predicted_direction_out;
    logic        instr_valid;

    int vectors     = 0;
    int miscompares = 0;

    fetch_stage_if imem_bus ();

    fetch_stage dut (
        .clk                     (clk),
        .rst                     (rst),
        .imem                    (imem_bus),
        .stall                   (stall),
        .redirect                (redirect),
        .redirect_pc             (redirect_pc),
        .bht_update              (bht_update),
        .bht_update_pc           (bht_update_pc),
        .bht_update_taken        (bht_update_taken),
        .pc_out                  (pc_out),
        .pc_plus4_out            (pc_plus4_out),
        .next_pc_out             (next_pc_out),
        .instr_out               (instr_out),
        .predicted_direction_out (predicted_direction_out),
        .instr_valid             (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall              = 1'b0;
        redirect           = 1'b0;
        redirect_pc        = 32'd0;
        bht_update         = 1'b0;
        bht_update_pc      = 32'd0;
        bht_update_taken   = 1'b0;
        imem_bus.imem_resp = 1'b0;
    endtask

    // Redirect landing together with imem_resp: word dropped, pc jumps straight to target.
    task automatic redirect_with_resp(input string tag, input logic [31:0] target);
        imem_bus.imem_resp  = 1'b1;
        imem_bus.imem_rdata = ADDI1;
        redirect            = 1'b1;
        redirect_pc         = target;
        #1;
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        tick();
        clear_inputs();
        #1;
        check({tag, "_addr"}, imem_bus.imem_address, target);
    endtask

    task automatic bht_push(input logic taken);
        bht_update       = 1'b1;
        bht_update_pc    = 32'h0000_0090;
        bht_update_taken = taken;
        tick();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        imem_bus.imem_rdata = 32'd0;
        rst = 1'b1;
        #2;
        check("rst_read",   {31'd0, imem_bus.imem_read}, 32'd0);
        check("rst_valid",  {31'd0, instr_valid}, 32'd0);
        check("rst_addr",   imem_bus.imem_address, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        tick();
        check("rst_read2",  {31'd0, imem_bus.imem_read}, 32'd0);
        rst = 1'b0;
        #1;

        check("t1_read",  {31'd0, imem_bus.imem_read}, 32'd1);
        check("t1_addr",  imem_bus.imem_address, 32'h60);
        check("t1_wait_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        imem_bus.imem_resp  = 1'b1;
        imem_bus.imem_rdata = ADDI1;
        #1;
        check("t1_resp_addr", imem_bus.imem_address, 32'h60);
        check("t1_valid",     {31'd0, instr_valid}, 32'd1);
        check("t1_pc_out",    pc_out, 32'h60);
        check("t1_plus4",     pc_plus4_out, 32'h64);
        check("t1_next_pc",   next_pc_out, 32'h64);
        check("t1_pred",      {31'd0, predicted_direction_out}, 32'd0);
        check("t1_instr",     instr_out, ADDI1);
        tick();
        clear_inputs();
        #1;
        check("t1_next_addr", imem_bus.imem_address, 32'h64);

        redirect_with_resp("t6_same_cycle", 32'h80);

        imem_bus.imem_resp  = 1'b1;
        imem_bus.imem_rdata = JAL;
        #1;
        check("t2_valid",   {31'd0, instr_valid}, 32'd1);
        check("t2_next_pc", next_pc_out, 32'h180);
        check("t2_pred",    {31'd0, predicted_direction_out}, 32'd1);
        tick();
        clear_inputs();
        #1;
        check("t2_next_addr", imem_bus.imem_address, 32'h180);

        redirect_with_resp("t3_go90", 32'h90);
        imem_bus.imem_resp  = 1'b1;
        imem_bus.imem_rdata = BEQ;
        bht_update          = 1'b1;
        bht_update_pc       = 32'h90;
        bht_update_taken    = 1'b1;
        #1;
        check("t3_first_valid", {31'd0, instr_valid}, 32'd1);
        check("t3_first_next",  next_pc_out, 32'h94);
        check("t3_first_pred",  {31'd0, predicted_direction_out}, 32'd0);
        tick();
        clear_inputs();
        bht_update       = 1'b1;
        bht_update_pc    = 32'h90;
        bht_update_taken = 1'b1;
        redirect_with_resp("t3_refetch", 32'h90);
        imem_bus.imem_resp  = 1'b1;
        imem_bus.imem_rdata = BEQ;
        #1;
        check("t3_taken_valid", {31'd0, instr_valid}, 32'd1);
        check("t3_taken_next",  next_pc_out, 32'h88);
        check("t3_taken_pred",  {31'd0, predicted_direction_out}, 32'd1);
        check("t3_taken_plus4", pc_plus4_out, 32'h94);
        tick();
        clear_inputs();
        #1;
        check("t3_target_addr", imem_bus.imem_address, 32'h88);

        imem_bus.imem_resp  = 1'b1;
        imem_bus.imem_rdata = ADDI2;
        stall               = 1'b1;
        #1;
        check("t4_capture_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        imem_bus.imem_resp  = 1'b0;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t4_hold_read",  {31'd0, imem_bus.imem_read}, 32'd0);
            check("t4_hold_valid", {31'd0, instr_valid}, 32'd0);
            check("t4_hold_pc",    pc_out, 32'h88);
            check("t4_hold_instr", instr_out, ADDI2);
            check("t4_hold_next",  next_pc_out, 32'h8C);
            tick();
        end
        stall = 1'b0;
        #1;
        check("t4_release_valid", {31'd0, instr_valid}, 32'd1);
        check("t4_release_instr", instr_out, ADDI2);
        check("t4_release_pc",    pc_out, 32'h88);
        tick();
        #1;
        check("t4_after_addr",  imem_bus.imem_address, 32'h8C);
        check("t4_after_read",  {31'd0, imem_bus.imem_read}, 32'd1);
        check("t4_after_valid", {31'd0, instr_valid}, 32'd0);

        redirect_with_resp("t5_goA0", 32'hA0);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        #1;
        check("t5_redir_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        clear_inputs();
        #1;
        check("t5_discard_addr", imem_bus.imem_address, 32'hA0);
        check("t5_discard_read", {31'd0, imem_bus.imem_read}, 32'd1);
        tick();
        imem_bus.imem_resp  = 1'b1;
        imem_bus.imem_rdata = ADDI1;
        #1;
        check("t5_drop_valid", {31'd0, instr_valid}, 32'd0);
        check("t5_drop_addr",  imem_bus.imem_address, 32'hA0);
        tick();
        clear_inputs();
        #1;
        check("t5_new_addr", imem_bus.imem_address, 32'h200);

        redirect    = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect_pc = 32'h340;
        #1;
        check("t5_overwrite_addr", imem_bus.imem_address, 32'h200);
        tick();
        clear_inputs();
        imem_bus.imem_resp = 1'b1;
        #1;
        check("t5_overwrite_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        clear_inputs();
        #1;
        check("t5_overwrite_target", imem_bus.imem_address, 32'h340);

        // Counter at 0x90 is 11; two more taken updates must not wrap it.
        redirect_with_resp("t6_sat_hi", 32'h90);
        bht_push(1'b1);
        bht_push(1'b1);
        imem_bus.imem_resp  = 1'b1;
        imem_bus.imem_rdata = BEQ;
        #1;
        check("t6_sat_hi_pred", {31'd0, predicted_direction_out}, 32'd1);
        check("t6_sat_hi_next", next_pc_out, 32'h88);
        tick();
        clear_inputs();
        redirect_with_resp("t6_sat_lo", 32'h90);
        for (int i = 0; i < 4; i++) begin
            bht_push(1'b0);
        end
        imem_bus.imem_resp  = 1'b1;
        imem_bus.imem_rdata = BEQ;
        #1;
        check("t6_sat_lo_pred", {31'd0, predicted_direction_out}, 32'd0);
        check("t6_sat_lo_next", next_pc_out, 32'h94);
        tick();
        clear_inputs();
        redirect_with_resp("t6_recover", 32'h90);
        bht_push(1'b1);
        bht_push(1'b1);
        imem_bus.imem_resp  = 1'b1;
        imem_bus.imem_rdata = BEQ;
        #1;
        check("t6_recover_pred", {31'd0, predicted_direction_out}, 32'd1);
        tick();
        clear_inputs();

        redirect    = 1'b1;
        redirect_pc = 32'h400;
        tick();
        clear_inputs();
        rst = 1'b1;
        #1;
        check("rst_mid_read", {31'd0, imem_bus.imem_read}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_addr", imem_bus.imem_address, 32'h60);
        check("rst_mid_read2", {31'd0, imem_bus.imem_read}, 32'd1);
        imem_bus.imem_resp  = 1'b1;
        imem_bus.imem_rdata = ADDI1;
        #1;
        check("rst_mid_valid", {31'd0, instr_valid}, 32'd1);
        check("rst_mid_pc",    pc_out, 32'h60);
        tick();
        clear_inputs();
        redirect_with_resp("rst_bht", 32'h90);
        imem_bus.imem_resp  = 1'b1;
        imem_bus.imem_rdata = BEQ;
        #1;
        check("rst_bht_pred", {31'd0, predicted_direction_out}, 32'd0);
        tick();
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
